// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU: condition codes, fetch FSM states and opcode constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    COND_NEVER = 3'b000,
    COND_EQZ   = 3'b001,
    COND_LTZ   = 3'b010,
    COND_LEZ   = 3'b011,
    COND_ALWAYS = 3'b100,
    COND_NEZ   = 3'b101,
    COND_GEZ   = 3'b110,
    COND_GT    = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } fetch_state_e;

  localparam logic [1:0] OPC_LOAD = 2'b00;
  localparam logic [1:0] OPC_ALU  = 2'b01;
  localparam logic [1:0] OPC_COPY = 2'b10;
  localparam logic [1:0] OPC_COND = 2'b11;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: tests a signed register value against a 3-bit code.
module cond_eval
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        cond_opc,
  input  logic [DATA_W-1:0] cond_value,
  output logic              taken
);

  logic zero;
  logic neg;

  assign zero = (cond_value == '0);
  assign neg  = cond_value[DATA_W-1];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond_opc))
      COND_NEVER:  taken = 1'b0;
      COND_EQZ:    taken = zero;
      COND_LTZ:    taken = neg;
      COND_LEZ:    taken = neg | zero;
      COND_ALWAYS: taken = 1'b1;
      COND_NEZ:    taken = ~zero;
      COND_GEZ:    taken = ~neg;
      COND_GT:     taken = ~neg & ~zero;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/branch stage: holds the PC, fetches one instruction byte per instruction over a
// req/valid handshake, presents it to the controller and resolves conditional jumps.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int             ADDR_W   = 8,
  parameter int             DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] databus,
  output logic              instr_valid,
  input  logic              pc_set,
  input  logic [2:0]        cond_opc,
  input  logic [DATA_W-1:0] cond_value,
  input  logic [DATA_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        fsm_state
);

  // Handshake: a request is raised with mem_req and mem_addr and is accepted on the first
  // rising edge where mem_req and mem_valid are both high (same-cycle valid allowed); until
  // then mem_req and mem_addr hold steady. mem_valid without mem_req is ignored.

  fetch_state_e state;
  logic         pending;
  logic         accept;
  logic         taken;

  cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .cond_opc   (cond_opc),
    .cond_value (cond_value),
    .taken      (taken)
  );

  // pending keeps the request alive once issued, so dropping run cannot abort it.
  assign mem_req   = reset & (state == FETCH) & (run | pending);
  assign mem_addr  = pc;
  assign accept    = mem_req & mem_valid;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      databus     <= '0;
      instr_valid <= 1'b0;
      pending     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (accept) begin
            databus     <= mem_rdata;
            instr_valid <= 1'b1;
            pending     <= 1'b0;
            state       <= DECODE;
          end else if (mem_req) begin
            pending <= 1'b1;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          if (pc_set && taken) pc <= jump_target[ADDR_W-1:0];
          else                 pc <= pc + ADDR_W'(1);
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, wait states, condition sweep,
// PC wrap, tight loop, and run/stray-data behaviour.
module tb_instr_fetch_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_valid;
  logic [7:0] databus;
  logic       instr_valid;
  logic       pc_set;
  logic [2:0] cond_opc;
  logic [7:0] cond_value;
  logic [7:0] jump_target;
  logic [7:0] pc;
  logic [1:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_pc;
  logic [7:0] exp_db;

  // Taken table, bit i = cond_opc i, for cond_value 00, 01, FF.
  logic [7:0] tk_tab [3] = '{8'h5A, 8'hF0, 8'h3C};
  logic [7:0] val_tab [3] = '{8'h00, 8'h01, 8'hFF};

  instr_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .databus     (databus),
    .instr_valid (instr_valid),
    .pc_set      (pc_set),
    .cond_opc    (cond_opc),
    .cond_value  (cond_value),
    .jump_target (jump_target),
    .pc          (pc),
    .fsm_state   (fsm_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // One zero-wait instruction starting in FETCH; returns in the following FETCH.
  task automatic fetch_one(input logic [7:0] data, input logic ps, input logic [2:0] opc,
                           input logic [7:0] val, input logic [7:0] tgt, input logic tk);
    run = 1'b1; mem_valid = 1'b1; mem_rdata = data;
    #1;
    chk("fetch_req", {7'd0, mem_req}, 8'd1);
    chk("fetch_addr", mem_addr, exp_pc);
    step();
    mem_valid = 1'b0; mem_rdata = 8'h00;
    pc_set = ps; cond_opc = opc; cond_value = val; jump_target = tgt;
    #1;
    chk("decode_iv", {7'd0, instr_valid}, 8'd1);
    chk("decode_db", databus, data);
    chk("decode_req", {7'd0, mem_req}, 8'd0);
    step();
    chk("exec_iv", {7'd0, instr_valid}, 8'd0);
    chk("exec_db", databus, data);
    step();
    pc_set = 1'b0;
    exp_pc = tk ? tgt : exp_pc + 8'd1;
    exp_db = data;
    #1;
    chk("next_pc", pc, exp_pc);
    chk("next_db", databus, data);
    chk("next_state", {6'd0, fsm_state}, 8'd0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; mem_valid = 1'b0; mem_rdata = 8'h00;
    pc_set = 1'b0; cond_opc = 3'd0; cond_value = 8'h00; jump_target = 8'h00;
    exp_pc = 8'h00; exp_db = 8'h00;

    // 1. Reset, including reset asserted while a request is outstanding
    step();
    #1;
    chk("rst_req", {7'd0, mem_req}, 8'd0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_db", databus, 8'h00);
    chk("rst_iv", {7'd0, instr_valid}, 8'd0);
    reset = 1'b1;
    #1;
    chk("req_after_release", {7'd0, mem_req}, 8'd1);
    step();
    reset = 1'b0;
    #1;
    chk("req_mid_reset", {7'd0, mem_req}, 8'd0);
    step();
    reset = 1'b1;
    fetch_one(8'h05, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

    // 2. Sequential fetch
    fetch_one(8'h11, 1'b0, 3'd4, 8'h00, 8'h80, 1'b0);
    fetch_one(8'h22, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    fetch_one(8'h33, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

    // 3. Wait states; run drops after the request is issued
    run = 1'b1; mem_valid = 1'b0; mem_rdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wait_req", {7'd0, mem_req}, 8'd1);
      chk("wait_addr", mem_addr, 8'h04);
      chk("wait_db", databus, exp_db);
      chk("wait_iv", {7'd0, instr_valid}, 8'd0);
      step();
      run = 1'b0;
    end
    fetch_one(8'h44, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

    // 4. Condition sweep
    for (int v = 0; v < 3; v++) begin
      for (int o = 0; o < 8; o++) begin
        logic [7:0] row;
        row = tk_tab[v];
        fetch_one(8'hC0 + 8'(o), 1'b1, 3'(o), val_tab[v], 8'h40, row[o]);
      end
    end
    // pc_set=0 suppresses an always-condition
    fetch_one(8'h01, 1'b0, 3'd4, 8'h00, 8'h20, 1'b0);

    // 5. Wrap and tight loop
    fetch_one(8'h02, 1'b1, 3'd4, 8'h00, 8'hFF, 1'b1);
    fetch_one(8'h03, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    chk("wrap_addr", mem_addr, 8'h00);
    fetch_one(8'h04, 1'b1, 3'd4, 8'h00, 8'h00, 1'b1);
    chk("loop_addr", mem_addr, 8'h00);

    // 6. run=0 stall and stray mem_valid
    run = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {7'd0, mem_req}, 8'd0);
      chk("stall_iv", {7'd0, instr_valid}, 8'd0);
      step();
    end
    mem_valid = 1'b1; mem_rdata = 8'hAA;
    #1;
    chk("stray_req", {7'd0, mem_req}, 8'd0);
    step();
    mem_valid = 1'b0;
    #1;
    chk("stray_db", databus, exp_db);
    chk("stray_iv", {7'd0, instr_valid}, 8'd0);
    chk("stray_state", {6'd0, fsm_state}, 8'd0);
    chk("stray_pc", pc, exp_pc);
    fetch_one(8'h55, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
